// File: rtl/comm_pkg.sv
// Shared definitions for the wireless command link: opcodes, ack byte and
// the state encodings of the copter-side frame responder.
package comm_pkg;

  localparam logic [7:0] CMD_SET_ROLL  = 8'h03;
  localparam logic [7:0] CMD_SET_THRST = 8'h05;
  localparam logic [7:0] CMD_CALIBRATE = 8'h06;

  localparam logic [7:0] POS_ACK = 8'hA5;

  typedef enum logic [1:0] {
    WAIT_CMD = 2'd0,
    WAIT_HI  = 2'd1,
    WAIT_LO  = 2'd2
  } rx_state_e;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_PEND = 2'd1,
    T_BUSY = 2'd2
  } tx_state_e;

endpackage

// File: rtl/cmd_frame_rspndr.sv
// Copter-side command link endpoint: builds {cmd, data_hi, data_lo} frames from
// UART byte strobes and pushes single-byte responses back through the UART.
module cmd_frame_rspndr
  import comm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  input  logic        tx_busy,
  input  logic        tx_done,
  output logic        trmt,
  output logic [7:0]  tx_data,
  output logic        cmd_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  input  logic [7:0]  resp,
  output logic        resp_sent,
  output logic        frm_err,
  output logic        resp_drop
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  rx_state_e        rx_st_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       cmd_q;
  logic [15:0]      data_q;
  logic             cmd_rdy_q;
  logic             frm_err_q;

  tx_state_e        tx_st_q;
  logic [7:0]       tx_data_q;
  logic             trmt_q;
  logic             resp_sent_q;
  logic             resp_drop_q;

  // A byte strobe takes precedence over expiry, so a late byte is still accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st_q   <= WAIT_CMD;
      cnt_q     <= '0;
      cmd_q     <= '0;
      data_q    <= '0;
      cmd_rdy_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      frm_err_q <= 1'b0;
      if (clr_cmd_rdy) begin
        cmd_rdy_q <= 1'b0;
      end
      if (rx_rdy) begin
        cnt_q <= '0;
        unique case (rx_st_q)
          WAIT_CMD: begin
            cmd_q     <= rx_data;
            cmd_rdy_q <= 1'b0;
            rx_st_q   <= WAIT_HI;
          end
          WAIT_HI: begin
            data_q[15:8] <= rx_data;
            rx_st_q      <= WAIT_LO;
          end
          WAIT_LO: begin
            data_q[7:0] <= rx_data;
            cmd_rdy_q   <= 1'b1;
            rx_st_q     <= WAIT_CMD;
          end
          default: rx_st_q <= WAIT_CMD;
        endcase
      end else if (rx_st_q != WAIT_CMD) begin
        if (cnt_q >= TMO_LAST) begin
          cnt_q     <= TMO_MAX;
          rx_st_q   <= WAIT_CMD;
          frm_err_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // tx_data is only loaded from T_IDLE, so it stays stable while a byte is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st_q     <= T_IDLE;
      tx_data_q   <= '0;
      trmt_q      <= 1'b0;
      resp_sent_q <= 1'b0;
      resp_drop_q <= 1'b0;
    end else begin
      trmt_q      <= 1'b0;
      resp_sent_q <= 1'b0;
      resp_drop_q <= 1'b0;
      unique case (tx_st_q)
        T_IDLE: begin
          if (send_resp) begin
            tx_data_q <= resp;
            if (tx_busy) begin
              tx_st_q <= T_PEND;
            end else begin
              trmt_q  <= 1'b1;
              tx_st_q <= T_BUSY;
            end
          end
        end
        T_PEND: begin
          resp_drop_q <= send_resp;
          if (!tx_busy) begin
            trmt_q  <= 1'b1;
            tx_st_q <= T_BUSY;
          end
        end
        T_BUSY: begin
          resp_drop_q <= send_resp;
          if (tx_done) begin
            resp_sent_q <= 1'b1;
            tx_st_q     <= T_IDLE;
          end
        end
        default: tx_st_q <= T_IDLE;
      endcase
    end
  end

  assign cmd_rdy   = cmd_rdy_q;
  assign cmd       = cmd_q;
  assign data      = data_q;
  assign frm_err   = frm_err_q;
  assign trmt      = trmt_q;
  assign tx_data   = tx_data_q;
  assign resp_sent = resp_sent_q;
  assign resp_drop = resp_drop_q;

endmodule

// File: tb/tb_cmd_frame_rspndr.sv
// Directed and randomized bench for cmd_frame_rspndr against a frame/response
// reference model; every output is compared after every clock edge.
module tb_cmd_frame_rspndr;

  localparam int unsigned T = 16;

  logic        clk = 1'b0;
  logic        rst, rx_rdy, tx_busy, tx_done, clr_cmd_rdy, send_resp;
  logic [7:0]  rx_data, resp;
  logic        trmt, cmd_rdy, resp_sent, frm_err, resp_drop;
  logic [7:0]  tx_data, cmd;
  logic [15:0] data;

  always #5 clk = ~clk;

  cmd_frame_rspndr #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .tx_busy(tx_busy), .tx_done(tx_done), .trmt(trmt), .tx_data(tx_data),
    .cmd_rdy(cmd_rdy), .cmd(cmd), .data(data), .clr_cmd_rdy(clr_cmd_rdy),
    .send_resp(send_resp), .resp(resp), .resp_sent(resp_sent),
    .frm_err(frm_err), .resp_drop(resp_drop)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned quiet  = 0;

  // Reference model: bytes of the partial frame, idle time since last byte,
  // and whether a response is held / already handed to the UART.
  logic [7:0]  part[$];
  int unsigned idle;
  logic        m_cmd_rdy, m_frm_err;
  logic [7:0]  m_cmd;
  logic [15:0] m_data;
  logic        m_has, m_launched;
  logic [7:0]  m_tx_data;
  logic        m_trmt, m_sent, m_drop;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    part.delete();
    idle = 0;
    m_cmd_rdy = 1'b0; m_frm_err = 1'b0; m_cmd = '0; m_data = '0;
    m_has = 1'b0; m_launched = 1'b0; m_tx_data = '0;
    m_trmt = 1'b0; m_sent = 1'b0; m_drop = 1'b0;
  endtask

  task automatic model_edge();
    logic had;
    if (rst) begin
      model_reset();
      return;
    end
    m_frm_err = 1'b0; m_trmt = 1'b0; m_sent = 1'b0; m_drop = 1'b0;
    if (clr_cmd_rdy) m_cmd_rdy = 1'b0;
    if (rx_rdy) begin
      idle = 0;
      case (part.size())
        0: begin m_cmd = rx_data; m_cmd_rdy = 1'b0; part.push_back(rx_data); end
        1: begin m_data[15:8] = rx_data; part.push_back(rx_data); end
        default: begin m_data[7:0] = rx_data; part.delete(); m_cmd_rdy = 1'b1; end
      endcase
    end else if (part.size() != 0) begin
      idle++;
      if (idle >= T) begin
        part.delete();
        m_frm_err = 1'b1;
      end
    end
    had = m_has;
    if (send_resp && had) m_drop = 1'b1;
    if (had && m_launched && tx_done) begin
      m_sent = 1'b1; m_has = 1'b0; m_launched = 1'b0;
    end
    if (send_resp && !had) begin
      m_has = 1'b1; m_tx_data = resp;
    end
    if (m_has && !m_launched && !tx_busy) begin
      m_trmt = 1'b1; m_launched = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("cmd_rdy",   cmd_rdy,   m_cmd_rdy);
    chk("cmd",       cmd,       m_cmd);
    chk("data",      data,      m_data);
    chk("frm_err",   frm_err,   m_frm_err);
    chk("trmt",      trmt,      m_trmt);
    chk("tx_data",   tx_data,   m_tx_data);
    chk("resp_sent", resp_sent, m_sent);
    chk("resp_drop", resp_drop, m_drop);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    rst = 1'b0; rx_rdy = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0; tx_done = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_rdy = 1'b1;
    rx_data = b;
    step();
  endtask

  task automatic idle_n(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) step();
  endtask

  initial begin
    model_reset();
    rx_rdy = 1'b0; rx_data = '0; tx_busy = 1'b0; tx_done = 1'b0;
    clr_cmd_rdy = 1'b0; send_resp = 1'b0; resp = '0;
    for (int i = 0; i < 3; i++) begin rst = 1'b1; step(); end
    chk("rst_cmd_rdy", cmd_rdy, 0);
    chk("rst_data", data, 0);
    chk("rst_trmt", trmt, 0);

    send_byte(8'h06); send_byte(8'h00);
    chk("f1_rdy_early", cmd_rdy, 0);
    send_byte(8'h00);
    chk("f1_rdy", cmd_rdy, 1);
    chk("f1_cmd", cmd, 16'h0006);
    chk("f1_data", data, 16'h0000);

    send_byte(8'h05); send_byte(8'h01); send_byte(8'hFF);
    idle_n(4);
    chk("f2_rdy_held", cmd_rdy, 1);
    clr_cmd_rdy = 1'b1;
    step();
    chk("f2_rdy_clr", cmd_rdy, 0);
    chk("f2_cmd", cmd, 16'h0005);
    chk("f2_data", data, 16'h01FF);

    send_byte(8'h03); send_byte(8'h00);
    idle_n(T - 1);
    chk("tmo_early", frm_err, 0);
    step();
    chk("tmo_err", frm_err, 1);
    chk("tmo_rdy", cmd_rdy, 0);
    step();
    chk("tmo_err_once", frm_err, 0);
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h50);
    chk("f3_cmd", cmd, 16'h0003);
    chk("f3_data", data, 16'h0050);

    tx_busy = 1'b0; send_resp = 1'b1; resp = 8'hA5;
    step();
    chk("r1_trmt", trmt, 1);
    chk("r1_txd", tx_data, 16'h00A5);
    tx_busy = 1'b1;
    idle_n(3);
    tx_busy = 1'b0; tx_done = 1'b1;
    step();
    chk("r1_sent", resp_sent, 1);
    step();

    tx_busy = 1'b1; send_resp = 1'b1; resp = 8'hA5;
    step();
    chk("r2_no_trmt", trmt, 0);
    send_resp = 1'b1; resp = 8'h5A;
    step();
    chk("r2_drop", resp_drop, 1);
    idle_n(2);
    tx_busy = 1'b0;
    step();
    chk("r2_trmt", trmt, 1);
    chk("r2_txd", tx_data, 16'h00A5);
    tx_busy = 1'b1; step();
    tx_busy = 1'b0; tx_done = 1'b1; step();
    chk("r2_sent", resp_sent, 1);

    send_byte(8'h77);
    rst = 1'b1;
    step();
    chk("mid_rst_cmd", cmd, 0);
    chk("mid_rst_tx", tx_data, 0);
    send_byte(8'h05); send_byte(8'h12); send_byte(8'h34);
    chk("f4_cmd", cmd, 16'h0005);
    chk("f4_data", data, 16'h1234);
    chk("f4_rdy", cmd_rdy, 1);

    for (int i = 0; i < 4000; i++) begin
      if (quiet > 0) quiet--;
      else if ($urandom_range(0, 40) == 0) quiet = $urandom_range(T - 2, T + 3);
      rx_rdy      = (quiet == 0) && ($urandom_range(0, 3) == 0);
      rx_data     = 8'($urandom);
      clr_cmd_rdy = ($urandom_range(0, 7) == 0);
      send_resp   = ($urandom_range(0, 5) == 0);
      resp        = 8'($urandom);
      if ($urandom_range(0, 4) == 0) tx_busy = ~tx_busy;
      tx_done     = ($urandom_range(0, 5) == 0);
      rst         = ($urandom_range(0, 499) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
